// File: rtl/semi_auto_driver_ctrl_pkg.sv
// ============================================================================
// semi_auto_driver_ctrl_pkg : state codes, command vectors and decode helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package semi_auto_driver_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_WAIT      = 3'b000,
      ST_TURN_L    = 3'b001,
      ST_TURN_R    = 3'b010,
      ST_MOVING    = 3'b011,
      ST_TURN_BACK = 3'b100,
      ST_LEAVE     = 3'b101
   } state_t;

   // Command vector order: {back, right, left, straight}
   localparam logic [3:0] CMD_STRAIGHT = 4'b0001;
   localparam logic [3:0] CMD_LEFT     = 4'b0010;
   localparam logic [3:0] CMD_RIGHT    = 4'b0100;
   localparam logic [3:0] CMD_BACK     = 4'b1000;

   // Detector vector order: {front, left, right}, 1 = wall
   localparam logic [2:0] DET_CORRIDOR   = 3'b011;
   localparam logic [2:0] DET_DEAD_END   = 3'b111;
   localparam logic [2:0] DET_LEFT_ONLY  = 3'b101;
   localparam logic [2:0] DET_RIGHT_ONLY = 3'b110;

   // Motor vector order: {forward, left, right}
   function automatic logic [2:0] motor_decode(input state_t s);
      case (s)
         ST_TURN_L:               return 3'b010;
         ST_TURN_R, ST_TURN_BACK: return 3'b001;
         ST_MOVING, ST_LEAVE:     return 3'b100;
         default:                 return 3'b000;
      endcase
   endfunction

   function automatic state_t junction_target(input logic [2:0] det, input logic auto_en);
      if (!auto_en) return ST_WAIT;
      case (det)
         DET_DEAD_END:   return ST_TURN_BACK;
         DET_LEFT_ONLY:  return ST_TURN_L;
         DET_RIGHT_ONLY: return ST_TURN_R;
         default:        return ST_WAIT;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/semi_auto_driver_ctrl_detector_sync.sv
// ============================================================================
// semi_auto_driver_ctrl_detector_sync : 3-bit two-flop synchroniser, resets to 1
// Revision: 1.0
// ============================================================================
`default_nettype none

module semi_auto_driver_ctrl_detector_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_async,
   output logic [2:0] o_sync
);

   logic [2:0] r_meta;
   logic [2:0] r_sync;

   // Walls are assumed present until real detector values have propagated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/semi_auto_driver_ctrl.sv
// ============================================================================
// semi_auto_driver_ctrl : junction command handling and timed manoeuvre FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module semi_auto_driver_ctrl
   import semi_auto_driver_ctrl_pkg::*;
#(
   parameter int TURN_CYCLES  = 90_000_000,
   parameter int BACK_CYCLES  = 180_000_000,
   parameter int LEAVE_CYCLES = 50_000_000,
   parameter int AUTO_MODE    = 0,
   parameter int CNT_W        = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       front_detector,
   input  logic       left_detector,
   input  logic       right_detector,
   input  logic       go_straight_command,
   input  logic       turn_left_command,
   input  logic       turn_right_command,
   input  logic       turn_back_command,
   output logic       move_forward_signal,
   output logic       turn_left_signal,
   output logic       turn_right_signal,
   output logic       cmd_reject,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] c_turn_last  = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_back_last  = CNT_W'(BACK_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_leave_last = CNT_W'(LEAVE_CYCLES - 1);
   localparam logic             c_auto_en    = (AUTO_MODE != 0);

   logic [2:0]       w_det;
   logic             w_f;
   logic             w_l;
   logic             w_r;
   logic [3:0]       w_cmd;
   logic             w_cmd_valid;
   logic             w_cmd_blocked;
   state_t           w_cmd_target;
   state_t           w_junction;

   state_t           r_state;
   logic [CNT_W-1:0] r_timer;
   logic [2:0]       r_motor;
   logic             r_cmd_reject;
   logic [3:0]       r_rej_cmd;

   semi_auto_driver_ctrl_detector_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async ({front_detector, left_detector, right_detector}),
      .o_sync  (w_det)
   );

   assign {w_f, w_l, w_r} = w_det;
   assign w_cmd       = {turn_back_command, turn_right_command, turn_left_command, go_straight_command};
   assign w_cmd_valid = $onehot(w_cmd);
   assign w_junction  = junction_target(w_det, c_auto_en);

   always_comb begin
      w_cmd_target  = ST_WAIT;
      w_cmd_blocked = 1'b0;
      case (w_cmd)
         CMD_STRAIGHT: begin w_cmd_target = ST_LEAVE;     w_cmd_blocked = w_f; end
         CMD_LEFT:     begin w_cmd_target = ST_TURN_L;    w_cmd_blocked = w_l; end
         CMD_RIGHT:    begin w_cmd_target = ST_TURN_R;    w_cmd_blocked = w_r; end
         CMD_BACK:     begin w_cmd_target = ST_TURN_BACK; w_cmd_blocked = 1'b0; end
         default:      ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_WAIT;
         r_timer      <= '0;
         r_motor      <= '0;
         r_cmd_reject <= 1'b0;
         r_rej_cmd    <= '0;
      end else begin
         r_cmd_reject <= 1'b0;
         r_rej_cmd    <= '0;
         r_timer      <= r_timer + 1'b1;
         case (r_state)
            ST_WAIT: begin
               r_timer <= '0;
               // r_rej_cmd remembers the refused pattern so a held command rejects once.
               if (w_cmd_valid && w_cmd_blocked) begin
                  r_cmd_reject <= (w_cmd != r_rej_cmd);
                  r_rej_cmd    <= w_cmd;
               end else if (w_cmd_valid) begin
                  r_state <= w_cmd_target;
                  r_motor <= motor_decode(w_cmd_target);
               end
            end
            ST_TURN_L, ST_TURN_R: begin
               if (r_timer == c_turn_last) begin
                  r_state <= ST_LEAVE;
                  r_motor <= motor_decode(ST_LEAVE);
                  r_timer <= '0;
               end
            end
            ST_TURN_BACK: begin
               if (r_timer == c_back_last) begin
                  r_state <= ST_LEAVE;
                  r_motor <= motor_decode(ST_LEAVE);
                  r_timer <= '0;
               end
            end
            ST_LEAVE: begin
               if (w_f) begin
                  r_state <= ST_WAIT;
                  r_motor <= '0;
                  r_timer <= '0;
               end else if (r_timer == c_leave_last) begin
                  r_state <= ST_MOVING;
                  r_motor <= motor_decode(ST_MOVING);
                  r_timer <= '0;
               end
            end
            ST_MOVING: begin
               r_timer <= '0;
               if (w_det != DET_CORRIDOR) begin
                  r_state <= w_junction;
                  r_motor <= motor_decode(w_junction);
               end
            end
            default: begin
               r_state <= ST_WAIT;
               r_motor <= '0;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign move_forward_signal = r_motor[2];
   assign turn_left_signal    = r_motor[1];
   assign turn_right_signal   = r_motor[0];
   assign cmd_reject          = r_cmd_reject;
   assign state               = r_state;

endmodule

`default_nettype wire

// File: tb/tb_semi_auto_driver_ctrl.sv
// ============================================================================
// tb_semi_auto_driver_ctrl : vector table, corner sequences, random vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_semi_auto_driver_ctrl;
   import semi_auto_driver_ctrl_pkg::*;

   localparam int TC = 4;
   localparam int BC = 8;
   localparam int LC = 3;

   localparam logic [3:0] N = 4'b0000;
   localparam logic [3:0] S = 4'b0001;
   localparam logic [3:0] L = 4'b0010;
   localparam logic [3:0] R = 4'b0100;
   localparam logic [3:0] B = 4'b1000;

   typedef struct {
      logic [2:0] det;
      logic [3:0] cmd;
      logic [2:0] st;
      logic [2:0] mot;
      logic       rej;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fd  = 1'b1;
   logic       ld  = 1'b1;
   logic       rd  = 1'b1;
   logic [3:0] cmd = 4'b0000;
   logic [1:0] mf;
   logic [1:0] tlo;
   logic [1:0] tro;
   logic [1:0] rj;
   logic [2:0] st [2];
   int         n_err = 0;
   int         n_chk = 0;
   vec_t       tbl [$];

   localparam int M_WAIT = 0, M_L = 1, M_R = 2, M_MOV = 3, M_BACK = 4, M_LEAVE = 5;
   int         m_mode [2];
   int         m_rem [2];
   logic [3:0] m_lastrej [2];
   logic       m_rej [2];
   logic [2:0] m_h0;
   logic [2:0] m_h1;

   always #5 clk = ~clk;

   semi_auto_driver_ctrl #(.TURN_CYCLES(TC), .BACK_CYCLES(BC), .LEAVE_CYCLES(LC),
                           .AUTO_MODE(0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .front_detector(fd), .left_detector(ld), .right_detector(rd),
      .go_straight_command(cmd[0]), .turn_left_command(cmd[1]),
      .turn_right_command(cmd[2]), .turn_back_command(cmd[3]),
      .move_forward_signal(mf[0]), .turn_left_signal(tlo[0]), .turn_right_signal(tro[0]),
      .cmd_reject(rj[0]), .state(st[0]));

   semi_auto_driver_ctrl #(.TURN_CYCLES(TC), .BACK_CYCLES(BC), .LEAVE_CYCLES(LC),
                           .AUTO_MODE(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .front_detector(fd), .left_detector(ld), .right_detector(rd),
      .go_straight_command(cmd[0]), .turn_left_command(cmd[1]),
      .turn_right_command(cmd[2]), .turn_back_command(cmd[3]),
      .move_forward_signal(mf[1]), .turn_left_signal(tlo[1]), .turn_right_signal(tro[1]),
      .cmd_reject(rj[1]), .state(st[1]));

   function automatic logic [6:0] obs(input int u);
      return {st[u], mf[u], tlo[u], tro[u], rj[u]};
   endfunction

   function automatic vec_t mk(input logic [2:0] d, input logic [3:0] c,
                               input logic [2:0] s, input logic [2:0] m, input logic j);
      vec_t v;
      v.det = d; v.cmd = c; v.st = s; v.mot = m; v.rej = j;
      return v;
   endfunction

   task automatic check(input string name, input int u, input logic [6:0] exp);
      logic [6:0] act;
      act = obs(u);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got state=%b fwd/l/r=%b rej=%b, expected state=%b fwd/l/r=%b rej=%b",
                  name, u, act[6:4], act[3:1], act[0], exp[6:4], exp[3:1], exp[0]);
      end
   endtask

   // Behavioural reference: counts down remaining manoeuvre time, detectors seen two edges late.
   task automatic model_reset();
      m_h0 = 3'b111;
      m_h1 = 3'b111;
      for (int u = 0; u < 2; u++) begin
         m_mode[u] = M_WAIT; m_rem[u] = 0; m_lastrej[u] = 4'b0000; m_rej[u] = 1'b0;
      end
   endtask

   task automatic model_step(input logic [3:0] c, input logic [2:0] d);
      logic [2:0] s;
      logic f, l, r, blocked;
      s = m_h1; m_h1 = m_h0; m_h0 = d;
      {f, l, r} = s;
      for (int u = 0; u < 2; u++) begin
         m_rej[u] = 1'b0;
         case (m_mode[u])
            M_WAIT: begin
               if ($countones(c) != 1) m_lastrej[u] = 4'b0000;
               else begin
                  blocked = (c == S && f) || (c == L && l) || (c == R && r);
                  if (blocked) begin
                     m_rej[u] = (c != m_lastrej[u]);
                     m_lastrej[u] = c;
                  end else if (c == S) begin m_mode[u] = M_LEAVE; m_rem[u] = LC; end
                  else if (c == L)     begin m_mode[u] = M_L;     m_rem[u] = TC; end
                  else if (c == R)     begin m_mode[u] = M_R;     m_rem[u] = TC; end
                  else                 begin m_mode[u] = M_BACK;  m_rem[u] = BC; end
               end
            end
            M_L, M_R, M_BACK: begin
               m_rem[u]--;
               if (m_rem[u] == 0) begin m_mode[u] = M_LEAVE; m_rem[u] = LC; end
            end
            M_LEAVE: begin
               if (f) m_mode[u] = M_WAIT;
               else begin
                  m_rem[u]--;
                  if (m_rem[u] == 0) m_mode[u] = M_MOV;
               end
            end
            M_MOV: begin
               if (s != 3'b011) begin
                  if (u == 1 && s == 3'b111)      begin m_mode[u] = M_BACK; m_rem[u] = BC; end
                  else if (u == 1 && s == 3'b101) begin m_mode[u] = M_L;    m_rem[u] = TC; end
                  else if (u == 1 && s == 3'b110) begin m_mode[u] = M_R;    m_rem[u] = TC; end
                  else m_mode[u] = M_WAIT;
               end
            end
            default: m_mode[u] = M_WAIT;
         endcase
         if (m_mode[u] != M_WAIT) m_lastrej[u] = 4'b0000;
      end
   endtask

   function automatic logic [6:0] m_exp(input int u);
      logic [2:0] mot;
      if (m_mode[u] == M_MOV || m_mode[u] == M_LEAVE) mot = 3'b100;
      else if (m_mode[u] == M_L)                      mot = 3'b010;
      else if (m_mode[u] == M_R || m_mode[u] == M_BACK) mot = 3'b001;
      else                                            mot = 3'b000;
      return {3'(m_mode[u]), mot, m_rej[u]};
   endfunction

   task automatic cyc(input logic [2:0] d, input logic [3:0] c);
      @(negedge clk);
      {fd, ld, rd} = d;
      cmd = c;
      @(posedge clk);
      model_step(c, d);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      {fd, ld, rd} = 3'b111;
      cmd = N;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [2:0] d;
      logic [3:0] c;
      int len, k;

      // Turn left, leave, corridor, corridor exit
      tbl.push_back(mk(3'b100, L, 3'b001, 3'b010, 0));
      tbl.push_back(mk(3'b011, L, 3'b001, 3'b010, 0));
      tbl.push_back(mk(3'b011, N, 3'b001, 3'b010, 0));
      tbl.push_back(mk(3'b011, N, 3'b001, 3'b010, 0));
      tbl.push_back(mk(3'b011, N, 3'b101, 3'b100, 0));
      tbl.push_back(mk(3'b011, N, 3'b101, 3'b100, 0));
      tbl.push_back(mk(3'b011, N, 3'b101, 3'b100, 0));
      tbl.push_back(mk(3'b011, N, 3'b011, 3'b100, 0));
      tbl.push_back(mk(3'b011, N, 3'b011, 3'b100, 0));
      tbl.push_back(mk(3'b001, N, 3'b011, 3'b100, 0));
      tbl.push_back(mk(3'b001, N, 3'b011, 3'b100, 0));
      tbl.push_back(mk(3'b001, N, 3'b000, 3'b000, 0));
      // Rejects and ignored multi-command patterns
      tbl.push_back(mk(3'b111, N, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, N, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, N, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, S, 3'b000, 3'b000, 1));
      tbl.push_back(mk(3'b111, S, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, S, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, L | R, 3'b000, 3'b000, 0));
      tbl.push_back(mk(3'b111, S, 3'b000, 3'b000, 1));
      tbl.push_back(mk(3'b111, N, 3'b000, 3'b000, 0));
      // Turn back is never refused; front wall aborts the following leave
      tbl.push_back(mk(3'b111, B, 3'b100, 3'b001, 0));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(3'b111, N, 3'b100, 3'b001, 0));
      tbl.push_back(mk(3'b111, N, 3'b101, 3'b100, 0));
      tbl.push_back(mk(3'b111, N, 3'b000, 3'b000, 0));

      model_reset();
      #12;
      check("reset", 0, 7'b0);
      check("reset", 1, 7'b0);
      @(negedge clk);
      rst = 1'b1;

      repeat (3) cyc(3'b100, N);
      foreach (tbl[i]) begin
         cyc(tbl[i].det, tbl[i].cmd);
         check($sformatf("vec%0d", i), 0, {tbl[i].st, tbl[i].mot, tbl[i].rej});
         check($sformatf("vec%0d", i), 1, {tbl[i].st, tbl[i].mot, tbl[i].rej});
      end

      // Auto dead end in MOVING
      do_reset();
      repeat (3) cyc(3'b011, N);
      cyc(3'b011, S);
      check("auto_enter_leave", 0, {3'b101, 3'b100, 1'b0});
      cyc(3'b011, S);
      cyc(3'b011, N);
      cyc(3'b011, N);
      check("auto_moving", 1, {3'b011, 3'b100, 1'b0});
      cyc(3'b111, N);
      cyc(3'b111, N);
      check("auto_latency", 1, {3'b011, 3'b100, 1'b0});
      cyc(3'b111, N);
      check("manual_dead_end", 0, {3'b000, 3'b000, 1'b0});
      check("auto_dead_end", 1, {3'b100, 3'b001, 1'b0});
      n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(3'b111, N);
         if (st[1] == 3'b100 && tro[1] == 1'b1) n++;
         else break;
      end
      n_chk++;
      if (n != BC) begin
         n_err++;
         $display("FAIL back_length: turn_right high %0d clocks, expected %0d", n, BC);
      end
      check("back_to_leave", 1, {3'b101, 3'b100, 1'b0});
      cyc(3'b111, N);
      check("leave_abort", 1, {3'b000, 3'b000, 1'b0});

      // Asynchronous reset in the middle of a right turn
      do_reset();
      repeat (3) cyc(3'b010, N);
      cyc(3'b010, R);
      cyc(3'b010, R);
      check("turn_r_cycle2", 0, {3'b010, 3'b001, 1'b0});
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_reset", 0, 7'b0);
      check("async_reset", 1, 7'b0);
      cmd = N;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc(3'b010, N);
      check("after_release", 1, 7'b0);
      cyc(3'b010, N);
      cyc(3'b010, N);
      cyc(3'b010, R);
      check("cmd_after_reset", 0, {3'b010, 3'b001, 1'b0});
      check("cmd_after_reset", 1, {3'b010, 3'b001, 1'b0});

      // Illegal state code recovers to WAIT
      do_reset();
      repeat (3) cyc(3'b111, N);
      @(negedge clk);
      force u_dut0.r_state = state_t'(3'b110);
      force u_dut1.r_state = state_t'(3'b111);
      #1;
      check("forced_illegal", 0, {3'b110, 3'b000, 1'b0});
      release u_dut0.r_state;
      release u_dut1.r_state;
      @(posedge clk);
      #1;
      check("illegal_recover", 0, 7'b0);
      check("illegal_recover", 1, 7'b0);

      // Randomised stimulus against the reference model
      do_reset();
      for (int seg = 0; seg < 250; seg++) begin
         k = $urandom_range(0, 9);
         d = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
         if (k < 4)      c = N;
         else if (k < 9) c = 4'b0001 << $urandom_range(0, 3);
         else            c = 4'($urandom_range(0, 15));
         len = $urandom_range(2, 5);
         for (int i = 0; i < len; i++) begin
            cyc(d, c);
            check("random", 0, m_exp(0));
            check("random", 1, m_exp(1));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
